// File: rtl/fd_pkg.sv
// Shared types and field-layout helpers for the fetch/decode front end.
// Bit offsets depend on the register index width, so they are exposed as functions of it.
package fd_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fd_state_e;

  localparam int NUM_FLAGS = 8;
  localparam int FLAG_LSB  = 0;
  localparam int DEST_LSB  = 8;

  function automatic int src1_lsb(input int reg_aw);
    return DEST_LSB + reg_aw;
  endfunction

  function automatic int src2_lsb(input int reg_aw);
    return DEST_LSB + 2 * reg_aw;
  endfunction

  function automatic int br_bit(input int reg_aw);
    return DEST_LSB + 3 * reg_aw;
  endfunction

  function automatic int halt_bit(input int reg_aw);
    return DEST_LSB + 3 * reg_aw + 1;
  endfunction

  function automatic int min_instr_w(input int reg_aw);
    return 10 + 3 * reg_aw;
  endfunction

  // Replicates bit w-1 of v into every bit above it.
  function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
    logic [63:0] hi;
    hi = {64{1'b1}} << w;
    return (((v >> (w - 1)) & 64'd1) != 64'd0) ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/fd_decoder.sv
// Purely combinational split of an instruction word into control flags,
// register indices and the branch/halt sequencing bits.
module fd_decoder
  import fd_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
) (
  input  logic [INSTR_W-1:0]   instr_i,
  output logic [NUM_FLAGS-1:0] flags_o,
  output logic [REG_AW-1:0]    dest_o,
  output logic [REG_AW-1:0]    src1_o,
  output logic [REG_AW-1:0]    src2_o,
  output logic                 branch_o,
  output logic                 halt_o
);

  localparam int SRC1_LSB = src1_lsb(REG_AW);
  localparam int SRC2_LSB = src2_lsb(REG_AW);
  localparam int BR_BIT   = br_bit(REG_AW);
  localparam int HALT_BIT = halt_bit(REG_AW);

  assign flags_o  = instr_i[FLAG_LSB +: NUM_FLAGS];
  assign dest_o   = instr_i[DEST_LSB +: REG_AW];
  assign src1_o   = instr_i[SRC1_LSB +: REG_AW];
  assign src2_o   = instr_i[SRC2_LSB +: REG_AW];
  assign branch_o = instr_i[BR_BIT];
  assign halt_o   = instr_i[HALT_BIT];

  // Bits above the halt bit carry no meaning for this datapath.
  if (INSTR_W > HALT_BIT + 1) begin : g_spare
    logic unused_hi;
    assign unused_hi = ^instr_i[INSTR_W-1:HALT_BIT+1];
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction-sequencing front end: owns the PC, fetches over a req/ready
// handshake, issues decoded control for one accepted cycle, supports sticky halt.
module fetch_decode_unit
  import fd_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              REG_AW   = 5,
  parameter int              TGT_W    = 5,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [PC_W-1:0]          imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ready,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic signed [TGT_W-1:0]  target,
  input  logic                     stall,
  output logic                     ctrl_valid,
  output logic                     alu_sum,
  output logic                     wb,
  output logic                     mem_wb,
  output logic                     imm_wb,
  output logic                     eq_in,
  output logic                     lt_in,
  output logic                     reset_st,
  output logic                     set_st,
  output logic [REG_AW-1:0]        dest,
  output logic [REG_AW-1:0]        source1,
  output logic [REG_AW-1:0]        source2,
  output logic                     halted,
  output logic [31:0]              retired
);

  if (INSTR_W < min_instr_w(REG_AW)) begin : g_instr_w_check
    $error("fetch_decode_unit: INSTR_W must be at least 10+3*REG_AW");
  end

  fd_state_e              state_q;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [31:0]            retired_q, retired_d;
  logic                   req_q;
  logic                   cv_q;
  logic                   halted_q;
  logic [NUM_FLAGS-1:0]   flags_q;
  logic [REG_AW-1:0]      dest_q, src1_q, src2_q;
  logic                   br_q, halt_q;

  logic [NUM_FLAGS-1:0]   dec_flags;
  logic [REG_AW-1:0]      dec_dest, dec_src1, dec_src2;
  logic                   dec_br, dec_halt;

  fd_decoder #(
    .INSTR_W (INSTR_W),
    .REG_AW  (REG_AW)
  ) u_dec (
    .instr_i  (imem_rdata),
    .flags_o  (dec_flags),
    .dest_o   (dec_dest),
    .src1_o   (dec_src1),
    .src2_o   (dec_src2),
    .branch_o (dec_br),
    .halt_o   (dec_halt)
  );

  // PC arithmetic wraps modulo 2^PC_W; a zero offset is a legal self-loop.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (br_q) begin
      pc_d = pc_q + PC_W'(sign_ext(64'($unsigned(target)), TGT_W));
    end
  end

  assign retired_d = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;

  // The instruction is held in decoded form; clearing it outside ISSUE keeps
  // the control outputs at zero without extra gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      req_q     <= 1'b0;
      cv_q      <= 1'b0;
      halted_q  <= 1'b0;
      flags_q   <= '0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      br_q      <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          req_q <= 1'b1;
          if (req_q && imem_ready) begin
            state_q <= ISSUE;
            req_q   <= 1'b0;
            cv_q    <= 1'b1;
            flags_q <= dec_flags;
            dest_q  <= dec_dest;
            src1_q  <= dec_src1;
            src2_q  <= dec_src2;
            br_q    <= dec_br;
            halt_q  <= dec_halt;
          end
        end
        ISSUE: begin
          if (!stall) begin
            retired_q <= retired_d;
            pc_q      <= pc_d;
            cv_q      <= 1'b0;
            flags_q   <= '0;
            dest_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            br_q      <= 1'b0;
            halt_q    <= 1'b0;
            if (halt_q) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
          cv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign imem_req   = req_q;
  assign ctrl_valid = cv_q;
  assign halted     = halted_q;
  assign retired    = retired_q;
  assign alu_sum    = flags_q[0];
  assign wb         = flags_q[1];
  assign mem_wb     = flags_q[2];
  assign imm_wb     = flags_q[3];
  assign eq_in      = flags_q[4];
  assign lt_in      = flags_q[5];
  assign reset_st   = flags_q[6];
  assign set_st     = flags_q[7];
  assign dest       = dest_q;
  assign source1    = src1_q;
  assign source2    = src2_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: a scoreboard of expected issues plus
// step-by-step checks of handshake, stall, halt, branch, reset and PC wrap.
module tb_fetch_decode_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Primary instance, default parameters
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [4:0]  target;
  logic        stall;
  logic        ctrl_valid;
  logic        alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st;
  logic [4:0]  dest, source1, source2;
  logic        halted;
  logic [31:0] retired;

  // Narrow-PC instance for wrap-around
  logic        rst2_n;
  logic [3:0]  addr2;
  logic        req2;
  logic        ready2;
  logic [31:0] rdata2;
  logic [4:0]  target2;
  logic        stall2;
  logic        cv2;
  logic        a2, w2, m2, i2, e2, l2, r2, s2;
  logic [4:0]  d2, sa2, sb2;
  logic        halted2;
  logic [31:0] ret2;

  logic [31:0] mem [0:31];
  assign imem_rdata = mem[imem_addr[4:0]];
  assign rdata2     = mem[{1'b0, addr2}];

  logic [7:0] flags;
  assign flags = {set_st, reset_st, lt_in, eq_in, imm_wb, mem_wb, wb, alu_sum};

  fetch_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .target(target), .stall(stall),
    .ctrl_valid(ctrl_valid), .alu_sum(alu_sum), .wb(wb), .mem_wb(mem_wb), .imm_wb(imm_wb),
    .eq_in(eq_in), .lt_in(lt_in), .reset_st(reset_st), .set_st(set_st),
    .dest(dest), .source1(source1), .source2(source2), .halted(halted), .retired(retired)
  );

  fetch_decode_unit #(.PC_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .imem_addr(addr2), .imem_req(req2),
    .imem_ready(ready2), .imem_rdata(rdata2), .target(target2), .stall(stall2),
    .ctrl_valid(cv2), .alu_sum(a2), .wb(w2), .mem_wb(m2), .imm_wb(i2),
    .eq_in(e2), .lt_in(l2), .reset_st(r2), .set_st(s2),
    .dest(d2), .source1(sa2), .source2(sb2), .halted(halted2), .retired(ret2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[4:0]];
    sb.push_back(e);
  endtask

  // Every accepted issue must match the next expected (pc, instruction) pair.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && ctrl_valid && !stall) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
      end else begin
        e.pc    = 32'hFFFF_FFFF;
        e.instr = 32'h0;
      end
      chk("sb_pc", imem_addr, e.pc);
      chk("sb_fields", {flags, dest, source1, source2},
          {e.instr[7:0], e.instr[12:8], e.instr[17:13], e.instr[22:18]});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(ctrl_valid === 1'b1 && imem_addr === a) && n < 300);
    chk("wait_issue", {ctrl_valid, imem_addr}, {1'b1, a});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rst2_n = 1'b0;
    imem_ready = 1'b1; stall = 1'b0; target = 5'd0;
    ready2 = 1'b1; stall2 = 1'b0; target2 = 5'd0;
    clear_mem();
    mem[0] = 32'h0000_0103;
    mem[1] = 32'h0004_2202;
    mem[3] = 32'h0100_0000;
    for (int i = 0; i < 4; i++) push(i);
    #2;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_cv", ctrl_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fields", {flags, dest, source1, source2}, 23'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Sequential fetch, first issue and stall hold
    step(1); chk("t1_req", {imem_req, ctrl_valid, imem_addr}, {1'b1, 1'b0, 32'd0});
    step(1); chk("t1_issue0", {ctrl_valid, alu_sum, wb, mem_wb, dest, imem_req},
                 {1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0});
    step(1); chk("t1_addr1", {ctrl_valid, imem_addr, retired}, {1'b0, 32'd1, 32'd1});
    step(1); chk("t3_issue1", ctrl_valid, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t3_hold_fields", {ctrl_valid, flags, dest, source1, source2},
          {1'b1, 8'h02, 5'd2, 5'd1, 5'd1});
      chk("t3_hold_pc", {imem_addr, retired}, {32'd1, 32'd1});
    end
    stall = 1'b0; imem_ready = 1'b0;
    step(1); chk("t3_advance", {ctrl_valid, imem_addr, retired}, {1'b0, 32'd2, 32'd2});

    // Memory not ready: request held, PC stable, no issue
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t4_wait", {imem_req, ctrl_valid, imem_addr}, {1'b1, 1'b0, 32'd2});
    end
    imem_ready = 1'b1;
    step(1); chk("t4_issue2", {ctrl_valid, flags}, {1'b1, 8'h00});

    // Halt
    step(2); chk("t5_halt_issue", {ctrl_valid, imem_addr, halted}, {1'b1, 32'd3, 1'b0});
    step(1); chk("t5_halted", {halted, imem_req, ctrl_valid, imem_addr, retired},
                 {1'b1, 1'b0, 1'b0, 32'd4, 32'd4});
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t5_frozen", {halted, imem_req, ctrl_valid, imem_addr}, {1'b1, 1'b0, 1'b0, 32'd4});
    end
    chk("sb_drain_1", sb.size(), 0);

    // Branches with negative then positive offset
    rst_n = 1'b0; sb.delete();
    clear_mem();
    mem[4] = 32'h0080_0000;
    target = 5'b11101;
    for (int i = 0; i < 5; i++) push(i);
    for (int i = 1; i < 5; i++) push(i);
    #1; @(posedge clk); #1; rst_n = 1'b1;
    wait_issue(32'd4);
    step(1); chk("t2_branch_neg", {imem_addr, imem_req}, {32'd1, 1'b1});
    target = 5'd15;
    wait_issue(32'd4);
    step(1); chk("t2_branch_pos", imem_addr, 32'd19);
    chk("t2_retired", retired, 32'd9);
    chk("sb_drain_2", sb.size(), 0);

    // Branch and halt together
    rst_n = 1'b0;
    clear_mem();
    mem[3] = 32'h0180_0000;
    target = 5'd2;
    for (int i = 0; i < 4; i++) push(i);
    #1; @(posedge clk); #1; rst_n = 1'b1;
    wait_issue(32'd3);
    step(1); chk("t5_br_halt", {halted, imem_req, ctrl_valid, imem_addr},
                 {1'b1, 1'b0, 1'b0, 32'd5});
    step(5); chk("t5_br_halt_frozen", {halted, imem_addr}, {1'b1, 32'd5});
    chk("sb_drain_3", sb.size(), 0);

    // Asynchronous reset in the middle of a stall
    rst_n = 1'b0;
    clear_mem();
    mem[9] = 32'h0000_0103;
    target = 5'd0;
    for (int i = 0; i < 9; i++) push(i);
    #1; @(posedge clk); #1; rst_n = 1'b1;
    wait_issue(32'd9);
    stall = 1'b1;
    step(3);
    chk("t6_stalled", {ctrl_valid, imem_addr, flags, dest}, {1'b1, 32'd9, 8'h03, 5'd1});
    chk("t6_stalled_ret", retired, 32'd9);
    #2; rst_n = 1'b0; #1;
    chk("t6_async_clear",
        {ctrl_valid, imem_req, halted, flags, dest, source1, source2, imem_addr, retired},
        128'd0);
    chk("sb_drain_4", sb.size(), 0);
    stall = 1'b0;

    // Narrow PC wrap-around: 14 + 3 mod 16 = 1
    clear_mem();
    mem[14] = 32'h0080_0000;
    target2 = 5'd3;
    @(posedge clk); #1; rst2_n = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(cv2 === 1'b1 && addr2 === 4'd14) && n < 300);
    chk("t6_wrap_reach", {cv2, addr2}, {1'b1, 4'd14});
    step(1); chk("t6_wrap", {addr2, req2, cv2}, {4'd1, 1'b1, 1'b0});
    chk("t6_wrap_ret", ret2, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
